// File: rtl/psum_writeback.sv
// psum_writeback: requantises 16-lane partial-sum vectors to int8 and writes each one
// as a single 16-byte AXI4 INCR burst. Define PSUM_WB_RELU_EN to clamp negative lanes to 0.
module psum_writeback #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int LANES              = 16,
  parameter int PSUM_W             = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]                   num_rows,
  input  logic [4:0]                    shift,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  input  logic                          psum_valid,
  input  logic [LANES*PSUM_W-1:0]       psum_data,
  output logic                          psum_ready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [31:0]                   m_axi_wdata,
  output logic [3:0]                    m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam logic signed [PSUM_W-1:0] SAT_HI = PSUM_W'(127);
  localparam logic signed [PSUM_W-1:0] SAT_LO = PSUM_W'(-128);

  typedef enum logic [2:0] {IDLE, CAPTURE, ADDR, DATA, RESP, FIN} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          base_q, base_d;
  logic [15:0]            rows_q, rows_d;
  logic [4:0]             shift_q, shift_d;
  logic [15:0]            row_idx_q, row_idx_d;
  logic [1:0]             beat_q, beat_d;
  logic                   err_q, err_d;
  logic [LANES-1:0][7:0]  quant_q, quant_d;
  logic [LANES-1:0][7:0]  lane_sat;
  logic [31:0]            beat_word;
  logic [AW-1:0]          awaddr_calc;
  logic                   last_row;

  // Per-lane arithmetic shift followed by int8 saturation of the incoming vector.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [PSUM_W-1:0] lane_raw;
    logic signed [PSUM_W-1:0] lane_sh;
    assign lane_raw = psum_data[gi*PSUM_W +: PSUM_W];
    assign lane_sh  = lane_raw >>> shift_q;
`ifdef PSUM_WB_RELU_EN
    assign lane_sat[gi] = lane_sh[PSUM_W-1] ? 8'h00 :
                          (lane_sh > SAT_HI) ? 8'h7F : lane_sh[7:0];
`else
    assign lane_sat[gi] = (lane_sh > SAT_HI) ? 8'h7F :
                          (lane_sh < SAT_LO) ? 8'h80 : lane_sh[7:0];
`endif
  end

  // Beat b carries lanes 4b..4b+3, lowest lane in the lowest byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_pack
    assign beat_word[gi*8 +: 8] = quant_q[{beat_q, 2'(gi)}];
  end

  assign awaddr_calc = base_q + (AW'(row_idx_q) << 4);
  assign last_row    = ({1'b0, row_idx_q} + 17'd1) >= {1'b0, rows_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_rows == 16'd0) ? FIN : CAPTURE;
      CAPTURE: if (psum_valid) state_d = ADDR;
      ADDR:    if (m_axi_awready) state_d = DATA;
      DATA:    if (m_axi_wready && (beat_q == 2'd3)) state_d = RESP;
      RESP:    if (m_axi_bvalid) state_d = last_row ? FIN : CAPTURE;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    psum_ready    = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_awaddr  = '0;
    m_axi_wvalid  = 1'b0;
    m_axi_wstrb   = 4'h0;
    m_axi_wlast   = 1'b0;
    m_axi_wdata   = 32'h0;
    m_axi_bready  = 1'b0;
    case (state_q)
      CAPTURE: begin
        busy       = 1'b1;
        psum_ready = 1'b1;
      end
      ADDR: begin
        busy          = 1'b1;
        m_axi_awvalid = 1'b1;
        m_axi_awaddr  = awaddr_calc;
      end
      DATA: begin
        busy         = 1'b1;
        m_axi_wvalid = 1'b1;
        m_axi_wstrb  = 4'hF;
        m_axi_wdata  = beat_word;
        m_axi_wlast  = (beat_q == 2'd3);
      end
      RESP: begin
        busy         = 1'b1;
        m_axi_bready = 1'b1;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  assign m_axi_awlen   = 8'd3;
  assign m_axi_awsize  = 3'd2;
  assign m_axi_awburst = 2'b01;
  assign err           = err_q;

  always_comb begin
    base_d    = base_q;
    rows_d    = rows_q;
    shift_d   = shift_q;
    row_idx_d = row_idx_q;
    beat_d    = beat_q;
    err_d     = err_q;
    quant_d   = quant_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = base_addr & ~AW'(4'hF);
          rows_d    = num_rows;
          shift_d   = shift;
          row_idx_d = 16'd0;
          err_d     = 1'b0;
        end
      end
      CAPTURE: begin
        if (psum_valid) begin
          quant_d = lane_sat;
          beat_d  = 2'd0;
        end
      end
      DATA: begin
        if (m_axi_wready) beat_d = beat_q + 2'd1;
      end
      RESP: begin
        // A bad response is recorded but the job carries on to the last row.
        if (m_axi_bvalid) begin
          row_idx_d = row_idx_q + 16'd1;
          if (m_axi_bresp != 2'b00) err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q    <= '0;
      rows_q    <= 16'd0;
      shift_q   <= 5'd0;
      row_idx_q <= 16'd0;
      beat_q    <= 2'd0;
      err_q     <= 1'b0;
      quant_q   <= '0;
    end else begin
      base_q    <= base_d;
      rows_q    <= rows_d;
      shift_q   <= shift_d;
      row_idx_q <= row_idx_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      quant_q   <= quant_d;
    end
  end

endmodule

// File: tb/tb_psum_writeback.sv
// Scoreboard bench for psum_writeback: jobs push expected AW/W/done records, a
// negedge monitor (which also plays the AXI slave) pops and compares them.
module tb_psum_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_rows;
  logic [4:0]  shift;
  logic        busy, done, err;
  logic        psum_valid;
  logic [383:0] psum_data;
  logic        psum_ready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

  psum_writeback dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .shift(shift), .busy(busy), .done(done), .err(err),
    .psum_valid(psum_valid), .psum_data(psum_data), .psum_ready(psum_ready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave behaviour knobs, written only by the main process.
  int aw_mode = 0;   // 0 always ready, 1 fixed delay, 2 random
  int aw_delay = 0;
  int w_mode = 0;    // 0 always ready, 1 toggle, 2 random
  int b_mode = 0;    // 0 immediate, 1 random delay
  int err_burst = -1;

  // Scoreboard queues and monitor statistics.
  logic [31:0] exp_aw[$];
  logic [32:0] exp_w[$];
  bit          exp_done_err[$];
  bit          exp_done_rows[$];
  int w_beats = 0, axi_act = 0, done_cnt = 0, b_total = 0;
  int neg_cnt = 0, last_b_neg = -10;

  logic [383:0] job_vecs[$];
  logic [23:0]  sat_pat [4] = '{24'h7FFFFF, 24'h800000, 24'h000100, 24'hFFFFF0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Reference: floor-divide by 2^sh, optional ReLU, clamp into int8.
  function automatic logic [7:0] ref_quant(input logic [23:0] raw, input logic [4:0] sh);
    longint v, d;
    v = longint'(raw);
    if (raw[23]) v = v - 64'sd16777216;
    d = longint'(1) << sh;
    if (v >= 0) v = v / d;
    else v = -((-v + d - 1) / d);
`ifdef PSUM_WB_RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  // Slave model + monitor, evaluated on the falling edge so that every handshake
  // it predicts is the one the DUT sees on the next rising edge.
  initial begin : sb_proc
    int aw_wait;
    bit aw_hs, w_hs, b_hs;
    int b_pending;
    aw_wait = 0; aw_hs = 0; w_hs = 0; b_hs = 0; b_pending = 0;
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (!rst_n) begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        aw_wait = 0; aw_hs = 0; w_hs = 0; b_hs = 0; b_pending = 0;
        exp_aw.delete(); exp_w.delete(); exp_done_err.delete(); exp_done_rows.delete();
        continue;
      end
      if (aw_hs) aw_wait = 0;
      if (b_hs) begin b_pending--; b_total++; end
      case (aw_mode)
        0:       m_axi_awready = 1'b1;
        1:       m_axi_awready = (aw_wait >= aw_delay);
        default: m_axi_awready = 1'($urandom_range(0, 1));
      endcase
      if (m_axi_awvalid) aw_wait++;
      case (w_mode)
        0:       m_axi_wready = 1'b1;
        1:       m_axi_wready = !m_axi_wready;
        default: m_axi_wready = 1'($urandom_range(0, 1));
      endcase
      m_axi_bvalid = (b_pending > 0) && (b_mode == 0 || $urandom_range(0, 2) == 0);
      m_axi_bresp  = (b_total == err_burst) ? 2'b10 : 2'b00;

      aw_hs = m_axi_awvalid && m_axi_awready;
      w_hs  = m_axi_wvalid && m_axi_wready;
      b_hs  = m_axi_bvalid && m_axi_bready;
      if (m_axi_awvalid || m_axi_wvalid) begin
        axi_act++;
        check("aw_w_exclusive", {m_axi_awvalid, m_axi_wvalid} == 2'b11, 0);
      end
      if (m_axi_awvalid) begin
        if (exp_aw.size() == 0) fail_evt("aw_unexpected");
        else begin
          check("awaddr", m_axi_awaddr, exp_aw[0]);
          if (aw_hs) begin
            check("aw_ctrl", {m_axi_awlen, m_axi_awsize, m_axi_awburst}, {8'd3, 3'd2, 2'b01});
            void'(exp_aw.pop_front());
          end
        end
      end
      if (m_axi_wvalid) begin
        if (exp_w.size() == 0) fail_evt("w_unexpected");
        else begin
          check("wbeat", {m_axi_wlast, m_axi_wdata}, exp_w[0]);
          if (w_hs) begin
            check("wstrb", m_axi_wstrb, 4'hF);
            void'(exp_w.pop_front());
            w_beats++;
            if (m_axi_wlast) b_pending++;
          end
        end
      end
      if (b_hs) last_b_neg = neg_cnt;
      if (done) begin
        if (exp_done_err.size() == 0) fail_evt("done_unexpected");
        else begin
          check("done_err", err, exp_done_err[0]);
          check("done_busy", busy, 0);
          if (exp_done_rows[0]) check("done_after_b", neg_cnt - last_b_neg, 1);
          void'(exp_done_err.pop_front());
          void'(exp_done_rows.pop_front());
        end
        done_cnt++;
      end
    end
  end

  task automatic prepare(input logic [31:0] base, input int rows, input logic [4:0] sh,
                         input int kind, input int err_idx);
    logic [383:0] v;
    logic [23:0]  lane;
    logic [31:0]  word;
    job_vecs.delete();
    for (int r = 0; r < rows; r++) begin
      for (int l = 0; l < 16; l++) begin
        case (kind)
          1:       lane = 24'(l);
          2:       lane = sat_pat[l % 4];
          default: lane = ($urandom_range(0, 3) == 0) ? 24'($urandom())
                                                      : 24'($urandom_range(0, 600) - 300);
        endcase
        v[l*24 +: 24] = lane;
      end
      job_vecs.push_back(v);
      exp_aw.push_back({base[31:4], 4'b0} + 32'(r) * 32'd16);
      for (int b = 0; b < 4; b++) begin
        for (int j = 0; j < 4; j++) word[j*8 +: 8] = ref_quant(v[(4*b+j)*24 +: 24], sh);
        exp_w.push_back({(b == 3), word});
      end
    end
    exp_done_err.push_back(err_idx >= 0 && err_idx < rows);
    exp_done_rows.push_back(rows != 0);
    err_burst = (err_idx < 0) ? -1 : b_total + err_idx;
  endtask

  task automatic pulse_start(input logic [31:0] base, input int rows, input logic [4:0] sh);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_rows = 16'(rows); shift = sh;
    @(posedge clk); #1;
    start = 1'b0; base_addr = $urandom(); num_rows = 16'($urandom()); shift = 5'($urandom());
  endtask

  task automatic feed_rows(input int rows, output bit ok);
    ok = 1'b1;
    for (int r = 0; r < rows; r++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      psum_valid = 1'b1;
      psum_data  = job_vecs[r];
      ok = 1'b0;
      for (int t = 0; t < 2000; t++) begin
        @(negedge clk);
        if (psum_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      psum_valid = 1'b0;
      psum_data  = {12{$urandom()}};
      if (!ok) begin fail_evt("psum_ready_timeout"); return; end
    end
  endtask

  task automatic run_job(input logic [31:0] base, input int rows, input logic [4:0] sh,
                         input int err_idx, input bit poke, input int kind);
    int beats0, act0, done0, cyc, t;
    bit ok, exp_err;
    exp_err = (err_idx >= 0 && err_idx < rows);
    prepare(base, rows, sh, kind, err_idx);
    beats0 = w_beats; act0 = axi_act; done0 = done_cnt;
    pulse_start(base, rows, sh);
    check("busy_after_start", busy, rows != 0);
    check("err_cleared", err, 0);
    cyc = 1;
    if (poke) begin
      start = 1'b1; base_addr = base + 32'h0010_0000; num_rows = 16'(rows + 3); shift = sh + 5'd7;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    feed_rows(rows, ok);
    if (!ok) return;
    t = 0;
    while (done_cnt == done0 && t < 3000) begin @(posedge clk); #1; t++; cyc++; end
    if (done_cnt == done0) begin fail_evt("done_timeout"); return; end
    if (rows == 0) begin
      check("noop_latency", cyc, 2);
      check("noop_axi", axi_act - act0, 0);
    end
    check("w_beat_count", w_beats - beats0, 4 * rows);
    check("queues_empty", exp_aw.size() + exp_w.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
    check("err_sticky", err, exp_err);
    check("idle_busy", busy, 0);
    $display("job base=0x%08h rows=%0d shift=%0d err=%0b", base, rows, sh, err);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {busy, done, err, psum_ready, m_axi_awvalid, m_axi_wvalid,
                           m_axi_wlast, m_axi_bready}, 8'h00);
    check({tag, "_awaddr"}, m_axi_awaddr, 0);
    check({tag, "_wdata"}, m_axi_wdata, 0);
  endtask

  task automatic reset_mid_burst();
    int done0, beats0, t;
    bit ok;
    aw_mode = 0; w_mode = 0; b_mode = 0;
    prepare(32'h3000_0040, 1, 5'd3, 0, -1);
    done0 = done_cnt; beats0 = w_beats;
    pulse_start(32'h3000_0040, 1, 5'd3);
    feed_rows(1, ok);
    if (!ok) return;
    t = 0;
    while (w_beats < beats0 + 2 && t < 200) begin @(posedge clk); #1; t++; end
    check("reset_reached_beat2", w_beats - beats0, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midburst_reset");
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("no_done_after_reset", done_cnt - done0, 0);
    $display("reset mid-burst at beat %0d", w_beats - beats0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst_n = 1'b0; start = 1'b0; base_addr = 32'h0; num_rows = 16'h0; shift = 5'h0;
    psum_valid = 1'b0; psum_data = '0;
    repeat (3) begin @(posedge clk); #1; end
    check_reset_outputs("init_reset");
    rst_n = 1'b1;

    run_job(32'h1000_0000, 1, 5'd0, -1, 1'b0, 1);
    run_job(32'h1000_0100, 1, 5'd0, -1, 1'b0, 2);
    run_job(32'h1000_0200, 1, 5'd4, -1, 1'b0, 2);
    run_job(32'h1000_0300, 1, 5'd2, -1, 1'b0, 2);

    aw_mode = 1; aw_delay = 5; w_mode = 1;
    run_job(32'h2000_0008, 3, 5'd3, -1, 1'b0, 0);
    aw_mode = 0; w_mode = 0;

    run_job(32'h4000_0000, 2, 5'd1, 0, 1'b0, 0);
    run_job(32'h4000_1000, 0, 5'd0, -1, 1'b0, 0);
    run_job(32'h5000_0020, 2, 5'd6, -1, 1'b1, 0);

    reset_mid_burst();
    run_job(32'h6000_0000, 1, 5'd0, -1, 1'b0, 1);

    for (int k = 0; k < 8; k++) begin
      aw_mode = $urandom_range(0, 2); aw_delay = $urandom_range(0, 3);
      w_mode = $urandom_range(0, 2); b_mode = $urandom_range(0, 1);
      run_job($urandom(), $urandom_range(1, 4), 5'($urandom_range(0, 12)),
              ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1,
              1'($urandom_range(0, 1)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
